// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI word assembler slice.
// Optional drop counter is enabled with SPI_DROP_CNT_EN.
package spi_pkg;

  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned WORD_BYTES_DEFAULT = 8;

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

endpackage

// File: rtl/spi_tx_serializer.sv
// Reply word register feeding tx_byte; loads at word boundaries and shifts
// up one byte per received byte, back-filling with TX_FILL.
module spi_tx_serializer
  import spi_pkg::*;
#(
  parameter int unsigned WORD_BYTES = WORD_BYTES_DEFAULT,
  parameter logic [7:0]  TX_FILL    = 8'h00
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         shift,
  input  logic                         reply_valid,
  input  logic [BYTE_W*WORD_BYTES-1:0] reply_data,
  output logic                         reply_ready,
  output logic [BYTE_W-1:0]            tx_byte
);

  localparam int unsigned WW = BYTE_W * WORD_BYTES;

  logic [WW-1:0] tx_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_reg <= {WORD_BYTES{TX_FILL}};
    end else if (load) begin
      tx_reg <= reply_valid ? reply_data : {WORD_BYTES{TX_FILL}};
    end else if (shift) begin
      tx_reg <= WW'({tx_reg, TX_FILL});
    end
  end

  assign reply_ready = load & reply_valid;
  assign tx_byte     = tx_reg[WW-1 -: BYTE_W];

endmodule

// File: rtl/spi_word_assembler.sv
// Packs SPI bytes MSB-first into words with a one-deep output buffer and
// drives reply bytes back out. Define SPI_DROP_CNT_EN for drop_count.
module spi_word_assembler
  import spi_pkg::*;
#(
  parameter int unsigned WORD_BYTES = WORD_BYTES_DEFAULT,
  parameter logic [7:0]  TX_FILL    = 8'h00
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         msg_start,
  input  logic                         msg_end,
  input  logic                         byte_valid,
  input  logic [7:0]                   byte_data,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic [BYTE_W*WORD_BYTES-1:0] word_data,
  output logic                         drop,
  output logic                         frag,
  output logic                         overflow,
  input  logic                         reply_valid,
  output logic                         reply_ready,
  input  logic [BYTE_W*WORD_BYTES-1:0] reply_data,
  output logic [7:0]                   tx_byte
`ifdef SPI_DROP_CNT_EN
  ,
  output logic [7:0]                   drop_count
`endif
);

  localparam int unsigned WW    = BYTE_W * WORD_BYTES;
  localparam int unsigned IDX_W = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt, idx_base;
  logic [WW-1:0]     shift, shift_nxt, shift_base, assembled;
  logic              active, take, word_done, can_load, load_word, lose, end_now;
  logic              frag_nxt;

  // msg_start acts as a same-cycle restart, so a coincident byte lands as byte 0.
  always_comb begin
    active     = msg_start | (state == RECV);
    take       = byte_valid & active;
    idx_base   = msg_start ? '0 : idx;
    shift_base = msg_start ? '0 : shift;
    word_done  = take & (idx_base == IDX_LAST);
    assembled  = WW'({shift_base, byte_data});
    can_load   = ~word_valid | word_ready;
    load_word  = word_done & can_load;
    lose       = word_done & ~can_load;
    end_now    = msg_end & active;
  end

  always_comb begin
    state_nxt = state;
    if (msg_start) state_nxt = RECV;
    if (end_now)   state_nxt = IDLE;
  end

  // The byte arriving with msg_end is folded in before the fragment test.
  always_comb begin
    idx_nxt   = idx_base;
    shift_nxt = shift_base;
    frag_nxt  = 1'b0;
    if (take) begin
      idx_nxt   = word_done ? '0 : idx_base + 1'b1;
      shift_nxt = word_done ? '0 : assembled;
    end
    if (end_now) begin
      frag_nxt  = (idx_nxt != '0);
      idx_nxt   = '0;
      shift_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      shift      <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
      drop       <= 1'b0;
      frag       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      shift      <= shift_nxt;
      word_valid <= load_word | (word_valid & ~word_ready);
      if (load_word) word_data <= assembled;
      drop       <= lose;
      frag       <= frag_nxt;
      overflow   <= overflow | lose;
    end
  end

`ifdef SPI_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (lose && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

  spi_tx_serializer #(
    .WORD_BYTES (WORD_BYTES),
    .TX_FILL    (TX_FILL)
  ) u_tx (
    .clk         (clk),
    .reset       (reset),
    .load        (msg_start | word_done),
    .shift       (take),
    .reply_valid (reply_valid),
    .reply_data  (reply_data),
    .reply_ready (reply_ready),
    .tx_byte     (tx_byte)
  );

endmodule

// File: tb/tb_spi_word_assembler.sv
// Directed bench for spi_word_assembler with WORD_BYTES=4, TX_FILL=8'h00.
module tb_spi_word_assembler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        msg_start = 1'b0, msg_end = 1'b0, byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        word_valid, word_ready = 1'b1;
  logic [31:0] word_data;
  logic        drop, frag, overflow;
  logic        reply_valid = 1'b0, reply_ready;
  logic [31:0] reply_data = '0;
  logic [7:0]  tx_byte;
`ifdef SPI_DROP_CNT_EN
  logic [7:0]  drop_count;
`endif

  int vectors = 0, miscompares = 0;
  int rr_cnt = 0, drop_seen = 0, frag_seen = 0, wv_cycles = 0;

  spi_word_assembler #(.WORD_BYTES(4), .TX_FILL(8'h00)) dut (
    .clk         (clk),
    .reset       (reset),
    .msg_start   (msg_start),
    .msg_end     (msg_end),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_data   (word_data),
    .drop        (drop),
    .frag        (frag),
    .overflow    (overflow),
    .reply_valid (reply_valid),
    .reply_ready (reply_ready),
    .reply_data  (reply_data),
    .tx_byte     (tx_byte)
`ifdef SPI_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic s, input logic e, input logic bv, input logic [7:0] bd);
    msg_start = s; msg_end = e; byte_valid = bv; byte_data = bd;
    #1 rr_cnt += int'(reply_ready);
    @(posedge clk); #1;
    msg_start = 1'b0; msg_end = 1'b0; byte_valid = 1'b0;
    drop_seen += int'(drop); frag_seen += int'(frag); wv_cycles += int'(word_valid);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    msg_start = 1'b0; msg_end = 1'b0; byte_valid = 1'b0; reply_valid = 1'b0;
    word_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rr_cnt = 0; drop_seen = 0; frag_seen = 0; wv_cycles = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL reset_word_valid got %b want 0", word_valid); end
    vectors++; if (word_data !== 32'h0) begin miscompares++; $display("FAIL reset_word_data got %h want 00000000", word_data); end
    vectors++; if ({drop, frag, overflow} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {drop, frag, overflow}); end
    vectors++; if (tx_byte !== 8'h00) begin miscompares++; $display("FAIL reset_tx_byte got %h want 00", tx_byte); end
    vectors++; if (reply_ready !== 1'b0) begin miscompares++; $display("FAIL reset_reply_ready got %b want 0", reply_ready); end
    apply_reset();
  endtask

  task automatic test_single_word();
    apply_reset();
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h11); drive(0, 0, 1, 8'h22); drive(0, 0, 1, 8'h33); drive(0, 0, 1, 8'h44);
    vectors++; if (word_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", word_valid); end
    vectors++; if (word_data !== 32'h11223344) begin miscompares++; $display("FAIL single_data got %h want 11223344", word_data); end
    drive(0, 1, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
    vectors++; if (wv_cycles !== 1) begin miscompares++; $display("FAIL single_valid_cycles got %0d want 1", wv_cycles); end
    vectors++; if (frag_seen !== 0) begin miscompares++; $display("FAIL single_no_frag got %0d want 0", frag_seen); end
  endtask

  task automatic test_drop();
    apply_reset();
    word_ready = 1'b0;
    drive(1, 0, 0, 8'h00);
    for (int i = 1; i <= 8; i++) drive(0, 0, 1, 8'(i));
    drive(0, 1, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
    vectors++; if (word_data !== 32'h01020304) begin miscompares++; $display("FAIL drop_held_data got %h want 01020304", word_data); end
    vectors++; if (word_valid !== 1'b1) begin miscompares++; $display("FAIL drop_held_valid got %b want 1", word_valid); end
    vectors++; if (drop_seen !== 1) begin miscompares++; $display("FAIL drop_pulses got %0d want 1", drop_seen); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL drop_overflow got %b want 1", overflow); end
    word_ready = 1'b1;
    drive(0, 0, 0, 8'h00);
    vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL drop_release got %b want 0", word_valid); end
  endtask

  task automatic test_frag();
    apply_reset();
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'hAA); drive(0, 0, 1, 8'hBB);
    drive(0, 1, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
    vectors++; if (frag_seen !== 1) begin miscompares++; $display("FAIL frag_pulses got %0d want 1", frag_seen); end
    vectors++; if (wv_cycles !== 0) begin miscompares++; $display("FAIL frag_no_word got %0d want 0", wv_cycles); end
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h11); drive(0, 0, 1, 8'h22); drive(0, 0, 1, 8'h33); drive(0, 0, 1, 8'h44);
    vectors++; if (word_data !== 32'h11223344) begin miscompares++; $display("FAIL frag_realign got %h want 11223344", word_data); end
    drive(0, 1, 0, 8'h00);
    vectors++; if (frag_seen !== 1) begin miscompares++; $display("FAIL frag_clean_end got %0d want 1", frag_seen); end
  endtask

  task automatic test_reply();
    logic [7:0] exp_tx [4];
    exp_tx = '{8'hAD, 8'hBE, 8'hEF, 8'h00};
    apply_reset();
    reply_data = 32'hDEADBEEF; reply_valid = 1'b1;
    drive(1, 0, 0, 8'h00);
    reply_valid = 1'b0;
    vectors++; if (tx_byte !== 8'hDE) begin miscompares++; $display("FAIL reply_tx0 got %h want de", tx_byte); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 8'h5A);
      vectors++; if (tx_byte !== exp_tx[i]) begin miscompares++; $display("FAIL reply_tx%0d got %h want %h", i + 1, tx_byte, exp_tx[i]); end
    end
    drive(0, 1, 0, 8'h00);
    vectors++; if (rr_cnt !== 1) begin miscompares++; $display("FAIL reply_ready_pulses got %0d want 1", rr_cnt); end
  endtask

  task automatic test_fill_and_reset();
    apply_reset();
    drive(1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 8'(8'h70 + i));
      vectors++; if (tx_byte !== 8'h00) begin miscompares++; $display("FAIL fill_tx%0d got %h want 00", i, tx_byte); end
    end
    word_ready = 1'b0;
    reply_data = 32'hCAFEF00D; reply_valid = 1'b1;
    drive(1, 0, 0, 8'h00);
    reply_valid = 1'b0;
    drive(0, 0, 1, 8'h01); drive(0, 0, 1, 8'h02); drive(0, 0, 1, 8'h03); drive(0, 0, 1, 8'h04);
    drive(0, 0, 1, 8'h05);
    reset = 1'b1;
    #1;
    vectors++; if ({word_valid, drop, frag, overflow} !== 4'b0000) begin miscompares++; $display("FAIL midreset_flags got %b want 0000", {word_valid, drop, frag, overflow}); end
    vectors++; if (word_data !== 32'h0) begin miscompares++; $display("FAIL midreset_data got %h want 00000000", word_data); end
    vectors++; if (tx_byte !== 8'h00) begin miscompares++; $display("FAIL midreset_tx got %h want 00", tx_byte); end
    @(posedge clk); #1;
    reset = 1'b0;
    word_ready = 1'b1;
    drive(0, 0, 1, 8'hEE); drive(0, 0, 1, 8'hEE); drive(0, 0, 1, 8'hEE); drive(0, 0, 1, 8'hEE);
    vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL idle_bytes_ignored got %b want 0", word_valid); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    drive(1, 0, 1, 8'hA1);
    drive(0, 0, 1, 8'hB2); drive(0, 0, 1, 8'hC3); drive(0, 0, 1, 8'hD4);
    vectors++; if (word_data !== 32'hA1B2C3D4) begin miscompares++; $display("FAIL start_byte0 got %h want a1b2c3d4", word_data); end
    drive(0, 0, 1, 8'h10); drive(0, 0, 1, 8'h20); drive(0, 0, 1, 8'h30); drive(0, 1, 1, 8'h40);
    vectors++; if (word_data !== 32'h10203040) begin miscompares++; $display("FAIL end_with_byte got %h want 10203040", word_data); end
    drive(0, 0, 0, 8'h00);
    vectors++; if (wv_cycles !== 2) begin miscompares++; $display("FAIL b2b_valid_cycles got %0d want 2", wv_cycles); end
    vectors++; if (frag_seen !== 0) begin miscompares++; $display("FAIL b2b_no_frag got %0d want 0", frag_seen); end
  endtask

`ifdef SPI_DROP_CNT_EN
  task automatic test_drop_count();
    apply_reset();
    word_ready = 1'b0;
    drive(1, 0, 0, 8'h00);
    for (int w = 0; w < 301; w++)
      for (int b = 0; b < 4; b++) drive(0, 0, 1, 8'(b));
    drive(0, 1, 0, 8'h00);
    vectors++; if (drop_seen !== 300) begin miscompares++; $display("FAIL dropcnt_pulses got %0d want 300", drop_seen); end
    vectors++; if (drop_count !== 8'hFF) begin miscompares++; $display("FAIL dropcnt_sat got %h want ff", drop_count); end
    word_ready = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_drop();
    test_frag();
    test_reply();
    test_fill_and_reset();
    test_back_to_back();
`ifdef SPI_DROP_CNT_EN
    test_drop_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
